// File: rtl/led_display_row_driver_pkg.sv
// Shared panel types for the LED display pipeline: row content layout,
// panel address width and the row driver phase encoding.
package led_display_row_driver_pkg;

    localparam int GL_NUM_COL_PIXELS = 16;
    localparam int GL_PANEL_ADDR_W   = 4;
    localparam int GL_COL_IDX_W      = (GL_NUM_COL_PIXELS > 1) ? $clog2(GL_NUM_COL_PIXELS) : 1;

    typedef logic [GL_COL_IDX_W-1:0] col_idx_t;

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] blue;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] red;
    } rgb_half_t;

    typedef struct packed {
        rgb_half_t top;
        rgb_half_t bot;
    } rgb_row_t;

    localparam int GL_RGB_ROW_W = $bits(rgb_row_t);

    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, SHOW} led_drv_state_t;

    // Panel pin order is {B,G,R} for one column of one half
    function automatic logic [2:0] pixel_bits(input rgb_half_t half, input col_idx_t idx);
        return {half.blue[idx], half.green[idx], half.red[idx]};
    endfunction

endpackage

// File: rtl/led_display_row_driver_shifter.sv
// Serialises one captured row onto the panel RGB pins, highest column first,
// with a CLK_DIV-prescaled shift clock; done is high on the last shift cycle.
module led_row_shifter
    import led_display_row_driver_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic     clk_in,
    input  logic     reset_in,
    input  logic     start,
    input  rgb_row_t row,
    output logic [2:0] rgb_top,
    output logic [2:0] rgb_bot,
    output logic     panel_clk,
    output logic     done
);

    localparam int       DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam col_idx_t COL_LAST = col_idx_t'(GL_NUM_COL_PIXELS - 1);

    rgb_row_t           row_q;
    col_idx_t           col_q;
    col_idx_t           col_nxt;
    logic [DIV_W-1:0]   div_q;
    logic               clk_q;
    logic               busy_q;
    logic [2:0]         top_q;
    logic [2:0]         bot_q;
    logic               div_end;

    assign div_end   = (div_q == DIV_LAST);
    assign col_nxt   = col_q - 1'b1;
    assign done      = busy_q && clk_q && div_end && (col_q == '0);
    assign rgb_top   = top_q;
    assign rgb_bot   = bot_q;
    assign panel_clk = clk_q;

    // Data changes only on the falling edge of the panel clock, so it is
    // stable for the whole low phase and held through the high phase.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            row_q  <= '0;
            col_q  <= '0;
            div_q  <= '0;
            clk_q  <= 1'b0;
            busy_q <= 1'b0;
            top_q  <= '0;
            bot_q  <= '0;
        end else if (start) begin
            row_q  <= row;
            col_q  <= COL_LAST;
            div_q  <= '0;
            clk_q  <= 1'b0;
            busy_q <= 1'b1;
            top_q  <= pixel_bits(row.top, COL_LAST);
            bot_q  <= pixel_bits(row.bot, COL_LAST);
        end else if (busy_q) begin
            if (div_end) begin
                div_q <= '0;
                clk_q <= !clk_q;
                if (clk_q) begin
                    if (col_q == '0) begin
                        busy_q <= 1'b0;
                    end else begin
                        col_q <= col_nxt;
                        top_q <= pixel_bits(row_q.top, col_nxt);
                        bot_q <= pixel_bits(row_q.bot, col_nxt);
                    end
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_display_row_driver.sv
// HUB75 row driver: takes one row per handshake and runs shift, blank, latch
// and show phases. Define LED_ROW_DRIVER_BRIGHTNESS_EN to add brightness_in.
module led_display_row_driver
    import led_display_row_driver_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int BLANK_CYCLES = 4,
    parameter int LATCH_CYCLES = 2,
    parameter int SHOW_CYCLES  = 2048
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic [GL_RGB_ROW_W-1:0]    row_in,
    input  logic                       row_valid_in,
    output logic                       row_ready_out,
    input  logic [GL_PANEL_ADDR_W-1:0] row_address_in,
`ifdef LED_ROW_DRIVER_BRIGHTNESS_EN
    input  logic [3:0]                 brightness_in,
`endif
    output logic [2:0]                 panel_rgb_top_out,
    output logic [2:0]                 panel_rgb_bot_out,
    output logic                       panel_clk_out,
    output logic                       panel_lat_out,
    output logic                       panel_oe_n_out,
    output logic [GL_PANEL_ADDR_W-1:0] panel_addr_out,
    output logic                       row_done_out
);

    localparam int CNT_MAX_BL = (BLANK_CYCLES > LATCH_CYCLES) ? BLANK_CYCLES : LATCH_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_BL > SHOW_CYCLES) ? CNT_MAX_BL : SHOW_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t BLANK_LAST = cnt_t'(BLANK_CYCLES - 1);
    localparam cnt_t LATCH_LAST = cnt_t'(LATCH_CYCLES - 1);
    localparam cnt_t SHOW_LAST  = cnt_t'(SHOW_CYCLES - 1);
`ifdef LED_ROW_DRIVER_BRIGHTNESS_EN
    localparam int   SHOW_STEP  = SHOW_CYCLES / 16;
`endif

    led_drv_state_t             state_q, state_d;
    cnt_t                       cnt_q, cnt_d;
    logic                       start;
    logic                       shift_done;
    logic                       in_window;
    logic                       lat_d, oe_n_d, done_d, latch_entry;
    logic [GL_PANEL_ADDR_W-1:0] addr_cap_q;
    logic [GL_PANEL_ADDR_W-1:0] addr_q;
    logic                       lat_q, oe_n_q, done_q;
`ifdef LED_ROW_DRIVER_BRIGHTNESS_EN
    logic [3:0]                 bright_q;
`endif

    assign row_ready_out  = (state_q == IDLE) && !reset_in;
    assign panel_lat_out  = lat_q;
    assign panel_oe_n_out = oe_n_q;
    assign panel_addr_out = addr_q;
    assign row_done_out   = done_q;

    led_row_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .start     (start),
        .row       (rgb_row_t'(row_in)),
        .rgb_top   (panel_rgb_top_out),
        .rgb_bot   (panel_rgb_bot_out),
        .panel_clk (panel_clk_out),
        .done      (shift_done)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Panel pins are registered from the next-state view so LAT/OE_N line up
    // exactly with the phase they belong to and never glitch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (row_valid_in && row_ready_out) begin
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end
            SHIFT: begin
                if (shift_done) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef LED_ROW_DRIVER_BRIGHTNESS_EN
        in_window = (int'(cnt_d) < (int'(bright_q) + 1) * SHOW_STEP);
`else
        in_window = 1'b1;
`endif
        lat_d       = (state_d == LATCH);
        oe_n_d      = !((state_d == SHOW) && in_window);
        done_d      = (state_d == SHOW) && (cnt_d == SHOW_LAST);
        latch_entry = (state_d == LATCH) && (state_q != LATCH);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            addr_cap_q <= '0;
            addr_q     <= '0;
            lat_q      <= 1'b0;
            oe_n_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            if (start) begin
                addr_cap_q <= row_address_in;
            end
            if (latch_entry) begin
                addr_q <= addr_cap_q;
            end
            lat_q  <= lat_d;
            oe_n_q <= oe_n_d;
            done_q <= done_d;
        end
    end

`ifdef LED_ROW_DRIVER_BRIGHTNESS_EN
    // Brightness is taken at LATCH entry so the SHOW window of this row
    // cannot change underneath it.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            bright_q <= '0;
        end else if (latch_entry) begin
            bright_q <= brightness_in;
        end
    end
`endif

endmodule
